scan_display_mux: RTL and testbench
===================================

Name: scan_display_mux

Overview:
- Parametrised, time-multiplexed display scanner for DIGITS-digit common-anode or common-cathode 7-segment or LED arrays.
- Holds a double-buffered frame of DIGITS nibbles/words and steps through digits at a programmable slot rate.
- Drives the selected digit's data to the segment decoder and one-hot digit strobes, with a blanking dead-time at the start of every slot to suppress ghosting.
- Sits between the value-producing logic (counters, BCD converters) and the segment decoder/pins.

Parameters:
- DIGITS, 4, number of digits scanned (>=2).
- WIDTH, 4, bits per digit value (>=1).
- PRESCALE, 1000, clock cycles per digit slot (>=2).
- BLANK, 10, cycles at slot start with all strobes inactive (0 <= BLANK < PRESCALE).
- STROBE_ACTIVE_LOW, 1, 1 = strobe asserted as 0, 0 = asserted as 1.

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RESET_N  input  1  asynchronous, active-low reset.
- DATA_IN  input  DIGITS*WIDTH  frame value; digit k at bits [k*WIDTH +: WIDTH].
- LOAD  input  1  single-cycle strobe: capture DATA_IN into the pending buffer.
- DIGIT_EN  input  DIGITS  per-digit enable; 0 keeps that digit's strobe inactive for its slot.
- DATA_OUT  output  WIDTH  value of the current digit, to the segment decoder.
- STROBE  output  DIGITS  one-hot digit drive, polarity per STROBE_ACTIVE_LOW.
- SEL  output  max(1,clog2(DIGITS))  index of the current digit.
- FRAME_START  output  1  one-cycle pulse in the first cycle of slot 0.

Behaviour:
- Reset (asynchronous, RESET_N=0):
  - Slot counter CNT=0, SEL=0.
  - Active and pending buffers = 0; pending-valid flag = 0.
  - DATA_OUT=0, STROBE all inactive (all 1s if active-low), FRAME_START=0.
- Slot counter CNT counts 0..PRESCALE-1.
  - At CNT==PRESCALE-1: CNT->0, and SEL increments.
  - SEL wraps DIGITS-1 -> 0; no values >= DIGITS ever appear.
  - Frame length = DIGITS*PRESCALE cycles.
- All outputs are registered and change only on clock edges, aligned to the CNT/SEL state:
  - DATA_OUT = active[SEL] in every cycle of the slot, including the blanking cycles.
  - STROBE bit SEL is asserted in cycles with CNT in [BLANK, PRESCALE-1] and DIGIT_EN[SEL]==1 (DIGIT_EN sampled each cycle). All other bits are inactive.
  - Never more than one bit is asserted.
  - FRAME_START = 1 exactly when SEL==0 and CNT==0.
- Double buffering:
  - LOAD=1 copies DATA_IN to pending and sets pending-valid.
  - At the frame boundary (SEL==DIGITS-1, CNT==PRESCALE-1), if pending-valid is set: active <= pending, pending-valid cleared. The new frame is visible from slot 0 of the next frame.
  - LOAD on the boundary cycle: DATA_IN is written directly to active, pending-valid is cleared, and the value shows in the next frame.
  - Multiple LOADs within a frame: last one wins.
  - No tearing: active never changes mid-frame.
- BLANK=0: no dead-time; the strobe is asserted for the whole slot.
- Reset asserted mid-frame: immediate return to reset state; any pending frame is discarded.
- DIGIT_EN change mid-slot: takes effect on the strobe one cycle later; SEL timing is unaffected.

Test Plan (DIGITS=4, WIDTH=4, PRESCALE=8, BLANK=2, STROBE_ACTIVE_LOW=1):
- Reset release, no LOAD -> SEL sequence 0,1,2,3,0 every 8 cycles; DATA_OUT=0; STROBE=1111 for CNT 0-1 of each slot, then 1110/1101/1011/0111; FRAME_START every 32 cycles.
- LOAD DATA_IN=16'h4321 mid-frame -> current frame keeps old digits; from the next FRAME_START, DATA_OUT=1,2,3,4 per slot.
- LOAD 16'hAAAA then LOAD 16'h5555 in the same frame -> next frame shows 5 on all digits; AAAA never appears.
- LOAD 16'h9876 exactly on the boundary cycle -> next frame shows 6,7,8,9; the following frame is unchanged.
- DIGIT_EN=4'b1010 -> STROBE stays 1111 during slots 0 and 2; 1101 in slot 1 and 0111 in slot 3 after blanking; SEL cadence unchanged.
- RESET_N pulsed low during slot 2 with pending data -> outputs immediately at reset values; after release, DATA_OUT=0 and the pending frame is never displayed.

Source files
------------

// File: rtl/scan_display_mux.sv
// scan_display_mux
// Time-multiplexed scanner for a DIGITS-digit 7-segment or LED array.
// It holds a double-buffered frame of DIGITS values and steps through the digits,
// spending PRESCALE clock cycles on each one. It drives the selected value to the
// segment decoder and raises a one-hot digit strobe. The first BLANK cycles of every
// slot keep all strobes inactive, which suppresses ghosting between digits.
//
// Ports:
//   CLK         system clock; all state changes on the rising edge
//   RESET_N     asynchronous, active-low reset
//   DATA_IN     frame value; digit k is at bits [k*WIDTH +: WIDTH]
//   LOAD        single-cycle strobe that captures DATA_IN into the pending buffer
//   DIGIT_EN    per-digit enable; 0 keeps that digit's strobe inactive
//   DATA_OUT    value of the current digit
//   STROBE      one-hot digit drive; asserted as 0 when STROBE_ACTIVE_LOW != 0
//   SEL         index of the current digit
//   FRAME_START one-cycle pulse in the first cycle of slot 0
module scan_display_mux #(
    parameter int DIGITS            = 4,
    parameter int WIDTH             = 4,
    parameter int PRESCALE          = 1000,
    parameter int BLANK             = 10,
    parameter int STROBE_ACTIVE_LOW = 1,
    parameter int SW                = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic                      CLK,
    input  logic                      RESET_N,
    input  logic [DIGITS*WIDTH-1:0]   DATA_IN,
    input  logic                      LOAD,
    input  logic [DIGITS-1:0]         DIGIT_EN,
    output logic [WIDTH-1:0]          DATA_OUT,
    output logic [DIGITS-1:0]         STROBE,
    output logic [SW-1:0]             SEL,
    output logic                      FRAME_START
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [DIGITS-1:0] STROBE_IDLE =
        (STROBE_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    logic [CW-1:0]           cnt_r;
    logic [SW-1:0]           sel_r;
    logic [DIGITS*WIDTH-1:0] active_r;
    logic [DIGITS*WIDTH-1:0] pending_r;
    logic                    pvalid_r;
    logic [WIDTH-1:0]        data_out_r;
    logic [DIGITS-1:0]       strobe_r;
    logic                    frame_start_r;

    logic                    last_cnt_s;
    logic                    frame_end_s;
    logic [CW-1:0]           cnt_nxt_s;
    logic [SW-1:0]           sel_nxt_s;
    logic [DIGITS*WIDTH-1:0] active_nxt_s;
    logic [DIGITS*WIDTH-1:0] pending_nxt_s;
    logic                    pvalid_nxt_s;
    logic [DIGITS-1:0]       onehot_s;
    logic [WIDTH-1:0]        data_nxt_s;
    logic [DIGITS-1:0]       strobe_nxt_s;
    logic                    frame_start_nxt_s;

    // Slot counter and digit index advance.
    always_comb begin
        last_cnt_s  = (cnt_r == CW'(PRESCALE - 1));
        frame_end_s = last_cnt_s && (sel_r == SW'(DIGITS - 1));
        cnt_nxt_s   = cnt_r;
        sel_nxt_s   = sel_r;
        if (last_cnt_s) begin
            cnt_nxt_s = {CW{1'b0}};
            if (sel_r == SW'(DIGITS - 1)) begin
                sel_nxt_s = {SW{1'b0}};
            end else begin
                sel_nxt_s = sel_r + SW'(1);
            end
        end else begin
            cnt_nxt_s = cnt_r + CW'(1);
            sel_nxt_s = sel_r;
        end
    end

    // Double buffer: active only changes on the frame-boundary edge, so a frame never tears.
    // A LOAD on that same edge bypasses pending and goes straight to active.
    always_comb begin
        active_nxt_s  = active_r;
        pending_nxt_s = pending_r;
        pvalid_nxt_s  = pvalid_r;
        if (frame_end_s) begin
            if (LOAD) begin
                active_nxt_s = DATA_IN;
                pvalid_nxt_s = 1'b0;
            end else if (pvalid_r) begin
                active_nxt_s = pending_r;
                pvalid_nxt_s = 1'b0;
            end else begin
                active_nxt_s = active_r;
                pvalid_nxt_s = 1'b0;
            end
        end else if (LOAD) begin
            pending_nxt_s = DATA_IN;
            pvalid_nxt_s  = 1'b1;
        end else begin
            pending_nxt_s = pending_r;
            pvalid_nxt_s  = pvalid_r;
        end
    end

    // Output values are computed from next state so the registered outputs line up with CNT/SEL.
    always_comb begin
        onehot_s   = {DIGITS{1'b0}};
        data_nxt_s = active_nxt_s[int'(sel_nxt_s)*WIDTH +: WIDTH];
        if ((int'(cnt_nxt_s) >= BLANK) && DIGIT_EN[sel_nxt_s]) begin
            onehot_s[sel_nxt_s] = 1'b1;
        end else begin
            onehot_s = {DIGITS{1'b0}};
        end
        if (STROBE_ACTIVE_LOW != 0) begin
            strobe_nxt_s = ~onehot_s;
        end else begin
            strobe_nxt_s = onehot_s;
        end
        frame_start_nxt_s = (sel_nxt_s == {SW{1'b0}}) && (cnt_nxt_s == {CW{1'b0}});
    end

    // State and output registers.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt_r         <= {CW{1'b0}};
            sel_r         <= {SW{1'b0}};
            active_r      <= {(DIGITS*WIDTH){1'b0}};
            pending_r     <= {(DIGITS*WIDTH){1'b0}};
            pvalid_r      <= 1'b0;
            data_out_r    <= {WIDTH{1'b0}};
            strobe_r      <= STROBE_IDLE;
            frame_start_r <= 1'b0;
        end else begin
            cnt_r         <= cnt_nxt_s;
            sel_r         <= sel_nxt_s;
            active_r      <= active_nxt_s;
            pending_r     <= pending_nxt_s;
            pvalid_r      <= pvalid_nxt_s;
            data_out_r    <= data_nxt_s;
            strobe_r      <= strobe_nxt_s;
            frame_start_r <= frame_start_nxt_s;
        end
    end

    assign DATA_OUT    = data_out_r;
    assign STROBE      = strobe_r;
    assign SEL         = sel_r;
    assign FRAME_START = frame_start_r;

endmodule

// File: tb/tb_scan_display_mux.sv
// Testbench for scan_display_mux with DIGITS=4, WIDTH=4, PRESCALE=8, BLANK=2, active-low strobes.
// The reference model tracks how many clock edges have passed since reset release,
// which frame is on display, and which frame is queued. Expected outputs are derived
// from those with plain arithmetic.
module tb_scan_display_mux;

    logic        CLK;
    logic        RESET_N;
    logic [15:0] DATA_IN;
    logic        LOAD;
    logic [3:0]  DIGIT_EN;
    logic [3:0]  DATA_OUT;
    logic [3:0]  STROBE;
    logic [1:0]  SEL;
    logic        FRAME_START;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // model state
    int          m_k;        // rising edges since reset release; 0 = reset state
    logic [15:0] m_shown;    // frame currently displayed
    logic [15:0] m_next;     // last frame loaded during the current frame
    bit          m_has;
    logic [3:0]  m_en;       // DIGIT_EN seen at the last edge

    scan_display_mux #(
        .DIGITS(4), .WIDTH(4), .PRESCALE(8), .BLANK(2), .STROBE_ACTIVE_LOW(1)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .LOAD(LOAD),
        .DIGIT_EN(DIGIT_EN), .DATA_OUT(DATA_OUT), .STROBE(STROBE), .SEL(SEL),
        .FRAME_START(FRAME_START)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Frame-level model: a frame ends every 32 edges. A load is queued, and the last
    // queued load goes on display when the frame ends.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_k     <= 0;
            m_shown <= 16'h0000;
            m_has   <= 1'b0;
            m_next  <= 16'h0000;
            m_en    <= 4'hF;
        end else begin
            m_k  <= m_k + 1;
            m_en <= DIGIT_EN;
            if ((m_k + 1) % 32 == 0) begin
                if (LOAD) m_shown <= DATA_IN;
                else if (m_has) m_shown <= m_next;
                m_has <= 1'b0;
            end else if (LOAD) begin
                m_next <= DATA_IN;
                m_has  <= 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at t=%0t k=%0d: got %h expected %h", name, $time, m_k, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_data(int k, logic [15:0] f);
        logic [15:0] v;
        v = f >> (4 * ((k / 8) % 4));
        return (k == 0) ? 4'h0 : v[3:0];
    endfunction

    function automatic logic [3:0] exp_strobe(int k, logic [3:0] en);
        logic [3:0] s;
        int d;
        s = 4'hF;
        d = (k / 8) % 4;
        if (k > 0 && (k % 8) >= 2 && en[d]) s[d] = 1'b0;
        return s;
    endfunction

    // Compare DUT outputs against the model every cycle, away from the rising edge.
    always @(negedge CLK) begin
        if (cmp_en) begin
            check("data_out", {12'h000, DATA_OUT}, {12'h000, exp_data(m_k, m_shown)});
            check("strobe",   {12'h000, STROBE},   {12'h000, exp_strobe(m_k, m_en)});
            check("sel",      {14'h0000, SEL},     {14'h0000, 2'((m_k / 8) % 4)});
            check("frame_start", {15'h0000, FRAME_START},
                  {15'h0000, (m_k > 0 && m_k % 32 == 0) ? 1'b1 : 1'b0});
        end
    end

    task automatic wait_k(input int target);
        int n;
        n = 0;
        while (m_k != target && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        if (m_k != target) begin
            failures++;
            checks++;
            $display("FAIL wait_k timeout: k=%0d expected %0d", m_k, target);
        end
    endtask

    task automatic pulse_load(input logic [15:0] v);
        DATA_IN = v;
        LOAD    = 1'b1;
        @(negedge CLK);
        LOAD    = 1'b0;
    endtask

    initial begin
        RESET_N  = 1'b0;
        DATA_IN  = 16'h0000;
        LOAD     = 1'b0;
        DIGIT_EN = 4'hF;
        repeat (3) @(negedge CLK);
        cmp_en = 1'b1;
        check("reset_strobe", {12'h000, STROBE}, 16'h000F);
        check("reset_fs", {15'h0000, FRAME_START}, 16'h0000);
        RESET_N = 1'b1;

        // Idle scanning: blanking, then a single active-low strobe.
        wait_k(9);  check("blank_slot1", {12'h000, STROBE}, 16'h000F);
        wait_k(10); check("strobe_slot1", {12'h000, STROBE}, 16'h000D);
        wait_k(31); check("strobe_slot3", {12'h000, STROBE}, 16'h0007);
        wait_k(32); check("frame_start_32", {15'h0000, FRAME_START}, 16'h0001);

        // Mid-frame load appears from the next frame.
        wait_k(40); pulse_load(16'h4321);
        wait_k(50); check("old_frame_kept", {12'h000, DATA_OUT}, 16'h0000);
        wait_k(64); check("new_d0", {12'h000, DATA_OUT}, 16'h0001);
        wait_k(72); check("new_d1", {12'h000, DATA_OUT}, 16'h0002);
        wait_k(80); check("new_d2", {12'h000, DATA_OUT}, 16'h0003);
        wait_k(88); check("new_d3", {12'h000, DATA_OUT}, 16'h0004);

        // Two loads within one frame: the last one wins.
        wait_k(100); pulse_load(16'hAAAA);
        wait_k(110); pulse_load(16'h5555);
        wait_k(128); check("last_wins_d0", {12'h000, DATA_OUT}, 16'h0005);
        wait_k(152); check("last_wins_d3", {12'h000, DATA_OUT}, 16'h0005);

        // Load on the boundary cycle itself.
        wait_k(159); pulse_load(16'h9876);
        check("boundary_d0", {12'h000, DATA_OUT}, 16'h0006);
        wait_k(184); check("boundary_d3", {12'h000, DATA_OUT}, 16'h0009);
        wait_k(192); check("boundary_keep", {12'h000, DATA_OUT}, 16'h0006);

        // Per-digit enables.
        wait_k(223); DIGIT_EN = 4'b1010;
        wait_k(226); check("en_slot0", {12'h000, STROBE}, 16'h000F);
        wait_k(234); check("en_slot1", {12'h000, STROBE}, 16'h000D);
        wait_k(242); check("en_slot2", {12'h000, STROBE}, 16'h000F);
        wait_k(250); check("en_slot3", {12'h000, STROBE}, 16'h0007);
        wait_k(260); check("en_mid_before", {12'h000, STROBE}, 16'h000F);
        DIGIT_EN = 4'b1111;
        wait_k(261); check("en_mid_after", {12'h000, STROBE}, 16'h000E);

        // Reset during slot 2 with a frame still pending.
        wait_k(270); pulse_load(16'hBEEF);
        wait_k(276);
        #2 RESET_N = 1'b0;
        #1;
        check("async_data", {12'h000, DATA_OUT}, 16'h0000);
        check("async_strobe", {12'h000, STROBE}, 16'h000F);
        check("async_sel", {14'h0000, SEL}, 16'h0000);
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        wait_k(40); check("pending_discarded", {12'h000, DATA_OUT}, 16'h0000);
        wait_k(70); check("pending_discarded2", {12'h000, DATA_OUT}, 16'h0000);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
